// File: rtl/sparse_group_sel_if.sv
// sparse_group_sel_if: valid/ready input and output streams of the sparse group selector
interface sparse_group_sel_if #(
    parameter int DATA_W  = 4,
    parameter int GROUP   = 4,
    parameter int LANES   = 2,
    parameter int NGROUPS = 4
);
    localparam int SEL_W = $clog2(GROUP);
    logic                              in_valid;
    logic                              in_ready;
    logic                              in_mode;
    logic [NGROUPS*GROUP*DATA_W-1:0]   in_data;
    logic [NGROUPS*LANES*SEL_W-1:0]    in_idx;
    logic                              out_valid;
    logic                              out_ready;
    logic [NGROUPS*LANES*DATA_W-1:0]   out_data;
    logic                              out_last;
    logic                              idx_err;
    modport master (
        output in_valid, in_mode, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_last, idx_err
    );
    modport slave (
        input  in_valid, in_mode, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_last, idx_err
    );
endinterface

// File: rtl/sparse_group_sel.sv
// sparse_group_sel: per-group sparse gather or dense multi-beat stream of 4-bit activations
module sparse_group_sel #(
    parameter int DATA_W  = 4,
    parameter int GROUP   = 4,
    parameter int LANES   = 2,
    parameter int NGROUPS = 4
) (
    input logic clk,
    input logic rst,
    sparse_group_sel_if.slave bus
);
    localparam int SEL_W  = $clog2(GROUP);
    localparam int NBEATS = GROUP / LANES;
    localparam int CNT_W  = NBEATS > 1 ? $clog2(NBEATS) : 1;
    localparam int IN_W   = NGROUPS * GROUP * DATA_W;
    localparam int IDX_W  = NGROUPS * LANES * SEL_W;
    localparam int OUT_W  = NGROUPS * LANES * DATA_W;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state, state_nx;
    logic [IN_W-1:0]    held_data, src_data;
    logic [IDX_W-1:0]   held_idx, src_idx;
    logic               held_mode, src_mode;
    logic [CNT_W-1:0]   beat_cnt, src_k;
    logic [OUT_W-1:0]   out_data, nx_data;
    logic               out_valid, out_last, idx_err, nx_last, nx_err;
    logic [SEL_W-1:0]   sel;
    logic               accept, advance;

    assign bus.in_ready  = !rst && (state == IDLE || (bus.out_ready && out_last));
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.idx_err   = idx_err;
    assign accept        = bus.in_valid && bus.in_ready;
    assign advance       = out_valid && bus.out_ready && !out_last;

    // next state: a new beat always lands in EMIT; a completed beat with nothing new drops to IDLE
    always_comb begin
        state_nx = accept ? EMIT : (state == EMIT && bus.out_ready && out_last) ? IDLE : state;
    end

    // build the next output beat from either the incoming beat (beat 0) or the held beat (next dense beat)
    always_comb begin
        src_data = accept ? bus.in_data : held_data;
        src_idx  = accept ? bus.in_idx : held_idx;
        src_mode = accept ? bus.in_mode : held_mode;
        src_k    = accept ? '0 : beat_cnt + 1'b1;
        nx_data  = '0;
        nx_err   = 1'b0;
        sel      = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            for (int l = 0; l < LANES; l++) begin
                sel = src_mode ? SEL_W'(int'(src_k) * LANES + l) : src_idx[(g*LANES+l)*SEL_W +: SEL_W];
                nx_data[(g*LANES+l)*DATA_W +: DATA_W] = src_data[(g*GROUP+int'(sel))*DATA_W +: DATA_W];
            end
            for (int l = 1; l < LANES; l++) begin
                if (!src_mode && src_idx[(g*LANES+l)*SEL_W +: SEL_W] <= src_idx[(g*LANES+l-1)*SEL_W +: SEL_W])
                    nx_err = 1'b1;
            end
        end
        nx_last = !src_mode || src_k == CNT_W'(NBEATS - 1);
    end

    // state, held beat, beat counter and registered outputs; outputs only change on load or advance
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            idx_err   <= 1'b0;
            beat_cnt  <= '0;
            held_data <= '0;
            held_idx  <= '0;
            held_mode <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= state_nx == EMIT;
            if (accept) begin
                held_data <= bus.in_data;
                held_idx  <= bus.in_idx;
                held_mode <= bus.in_mode;
                beat_cnt  <= '0;
            end else if (advance) begin
                beat_cnt  <= beat_cnt + 1'b1;
            end
            if (accept || advance) begin
                out_data <= nx_data;
                out_last <= nx_last;
                idx_err  <= nx_err;
            end
        end
    end
endmodule

// File: tb/tb_sparse_group_sel.sv
// tb_sparse_group_sel: directed and randomized checks against a beat-queue reference model
module tb_sparse_group_sel;
    localparam int DW = 4, G = 4, L = 2, NG = 4;
    localparam int SW = $clog2(G), NB = G / L;
    localparam int IW = NG * G * DW, XW = NG * L * SW, OW = NG * L * DW;

    typedef struct {
        logic [OW-1:0] d;
        logic          last;
        logic          err;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    beat_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sparse_group_sel_if #(.DATA_W(DW), .GROUP(G), .LANES(L), .NGROUPS(NG)) bus ();
    sparse_group_sel #(.DATA_W(DW), .GROUP(G), .LANES(L), .NGROUPS(NG)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected output beats of one input beat, straight from the selection rules
    task automatic push_beats(input logic [IW-1:0] d, input logic [XW-1:0] x, input logic m);
        int nb;
        int c, pc;
        beat_t b;
        logic err;
        err = 1'b0;
        if (!m)
            for (int g = 0; g < NG; g++)
                for (int l = 1; l < L; l++) begin
                    c  = int'(x[(g*L+l)*SW +: SW]);
                    pc = int'(x[(g*L+l-1)*SW +: SW]);
                    if (c <= pc) err = 1'b1;
                end
        nb = m ? NB : 1;
        for (int k = 0; k < nb; k++) begin
            b.d = '0;
            for (int g = 0; g < NG; g++)
                for (int l = 0; l < L; l++) begin
                    c = m ? k * L + l : int'(x[(g*L+l)*SW +: SW]);
                    b.d[(g*L+l)*DW +: DW] = d[(g*G+c)*DW +: DW];
                end
            b.last = (k == nb - 1);
            b.err  = err;
            q.push_back(b);
        end
    endtask

    // one clock cycle: drive, check against the model, then advance the model over the coming edge
    task automatic step(input logic iv, input logic m, input logic [IW-1:0] d, input logic [XW-1:0] x,
                        input logic ordy, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.in_idx    = x;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (q.size() == 0) || (ordy && q.size() == 1);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_last", bus.out_last, q[0].last);
            chk("idx_err", bus.idx_err, q[0].err);
        end
        if (q.size() != 0 && ordy) void'(q.pop_front());
        acc = iv && exp_rdy;
        if (acc) push_beats(d, x, m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_idx_err", bus.idx_err, 0);
        chk("rst_beat_cnt", dut.beat_cnt, 0);
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        logic acc, hold, iv, m, ordy;
        logic [IW-1:0] d, dd;
        logic [XW-1:0] x;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        d = {48'h0123_4567_89AB, 16'hFA73};
        step(1, 0, d, 16'h444D, 1, acc);
        chk("sparse_acc", acc, 1);
        step(0, 0, d, 16'h0, 1, acc);
        chk("sparse_lanes", bus.out_data[7:0], 8'hF7);
        chk("sparse_last", bus.out_last, 1);
        chk("sparse_err", bus.idx_err, 0);

        step(1, 0, d, 16'h444A, 1, acc);
        step(1, 0, d, 16'h4443, 1, acc);
        chk("err1_lanes", bus.out_data[7:0], 8'hAA);
        chk("err1_flag", bus.idx_err, 1);
        step(0, 0, d, 16'h0, 1, acc);
        chk("err2_lanes", bus.out_data[7:0], 8'h3F);
        chk("err2_flag", bus.idx_err, 1);

        dd = {48'hFEDC_BA98_7654, 16'h4321};
        step(1, 1, dd, 16'h0, 1, acc);
        step(0, 0, d, 16'h0, 1, acc);
        chk("dense_b0", bus.out_data[7:0], 8'h21);
        chk("dense_b0_last", bus.out_last, 0);
        chk("dense_b0_rdy", bus.in_ready, 0);
        step(0, 0, d, 16'h0, 1, acc);
        chk("dense_b1", bus.out_data[7:0], 8'h43);
        chk("dense_b1_last", bus.out_last, 1);
        chk("dense_b1_rdy", bus.in_ready, 1);

        step(1, 1, dd, 16'h0, 1, acc);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, d, 16'h444D, 0, acc);
            chk("stall_cnt", dut.beat_cnt, 0);
            chk("stall_acc", acc, 0);
        end
        step(1, 0, d, 16'h444D, 1, acc);
        chk("resume_b0", bus.out_data[7:0], 8'h21);
        step(1, 0, d, 16'h444D, 1, acc);
        chk("resume_b1", bus.out_data[7:0], 8'h43);
        chk("resume_acc", acc, 1);
        step(0, 0, d, 16'h0, 1, acc);

        for (int i = 0; i < 8; i++) begin
            step(1, 0, {$urandom, $urandom}, 16'(4'h4 * i + 16'h4440), 1, acc);
            chk("b2b_acc", acc, 1);
        end
        step(0, 0, d, 16'h0, 1, acc);
        step(0, 0, d, 16'h0, 1, acc);

        step(1, 1, dd, 16'h0, 1, acc);
        step(0, 0, d, 16'h0, 1, acc);
        do_reset();
        step(0, 0, d, 16'h0, 1, acc);
        step(1, 0, d, 16'h444D, 1, acc);
        step(0, 0, d, 16'h0, 1, acc);
        chk("post_rst_lanes", bus.out_data[7:0], 8'hF7);

        hold = 1'b0;
        iv = 1'b0;
        m = 1'b0;
        x = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold) begin
                iv = ($urandom_range(0, 3) != 0);
                m  = $urandom_range(0, 1) == 1;
                d  = {$urandom, $urandom};
                x  = 16'($urandom);
            end
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, m, d, x, ordy, acc);
            hold = iv && !acc;
        end
        step(0, 0, d, 16'h0, 1, acc);
        step(0, 0, d, 16'h0, 1, acc);
        step(0, 0, d, 16'h0, 1, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
